reg_scoreboard: RTL
===================

# reg_scoreboard

Pipeline interlock scoreboard for the 3-stage MIPS datapath. It is the writer-side complement of the M→E / M→F forwarding unit. Forwarding resolves single-cycle producers. This block tracks registers whose writes are still in flight from long-latency producers: cache-miss loads and multiply/divide. It raises a stall whenever an instruction in Fetch reads, or would overwrite, such a register.

## Interface
- NREG, 32: architectural register count; r0 is never tracked.
- MAX_OUT, 4: maximum outstanding long-latency writes; range 1–15.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rsF  in  5  source A of the instruction in Fetch.
- rtF  in  5  source B of the instruction in Fetch.
- rsUsedF  in  1  rsF is a real read.
- rtUsedF  in  1  rtF is a real read.
- issueValid  in  1  the instruction leaving Fetch is a long-latency writer.
- issueWa  in  5  destination of that writer.
- flush  in  1  kill the instruction in Fetch; no issue is accepted this cycle.
- wbValid  in  1  a long-latency result is being written back this cycle.
- wbWa  in  5  destination of that writeback.
- stallF  out  1  hold Fetch and bubble Execute; combinational.
- pending  out  NREG  registered pending bit per register; bit 0 is always 0.
- outCnt  out  4  registered count of outstanding long writes.
- sbErr  out  1  sticky; set by a writeback to a non-pending register.

## Operation
- Effective pending view: pendEff[r] = pending[r] & ~(wbValid & wbWa==r & r!=0). A writeback therefore clears its hazard in the same cycle.
- rawA = rsUsedF & rsF!=0 & pendEff[rsF]. rawB is the same for rtF.
- waw = issueValid & issueWa!=0 & pendEff[issueWa].
- full = (outCnt == MAX_OUT) & ~wbLegal.
  - wbLegal = wbValid & wbWa!=0 & pending[wbWa].
- stallF = ~flush & (rawA | rawB | waw | (issueValid & full)).
- accept = issueValid & issueWa!=0 & ~stallF & ~flush. Issues to r0 are dropped silently.
- Next state:
  - pending[wbWa] is cleared when wbLegal.
  - pending[issueWa] is set when accept. Set wins when issue and writeback target the same register.
  - outCnt += accept − wbLegal.
- Illegal writeback: wbValid with wbWa==0 or pending[wbWa]==0.
  - State is unchanged and sbErr is set.
  - sbErr clears only on reset.
- flush has priority: it forces stallF=0 and accept=0. Writebacks are still processed during flush.

## Timing
- Reset (rst_n low, asynchronous): pending=0, outCnt=0, sbErr=0. stallF then follows its combinational definition, so it is 0 when there are no inputs.
- Reset mid-operation discards all in-flight tracking. The datapath reset guarantees no stale writebacks return.
- Latency:
  - An accepted issue in cycle N makes pending visible from N+1. A dependent reader in N+1 stalls.
  - A writeback in cycle N releases dependent readers in N itself, through the bypass.
  - The registered pending bit clears at N+1.
- stallF has no registered path from inputs. It must settle within the cycle, ahead of the Fetch PC enable.
- Full boundary: with outCnt==MAX_OUT, a new issue is accepted only when a legal writeback occurs in the same cycle. outCnt stays at MAX_OUT and never exceeds it.
- Empty boundary: outCnt==0 with wbValid is always illegal, so it sets sbErr. outCnt never wraps below 0.

## Structure
- The shared pipeline package holds:
  - REG_ZERO = 5'd0.
  - The NREG default.
  - The outCnt width constant.
  - The reg-address typedef shared with the forwarding unit.
- One sub-module, sb_hazard_chk: purely combinational.
  - Takes pending, the rs/rt/issue/wb addresses and their valids.
  - Produces rawA, rawB, waw and wbLegal.
  - The top level holds the registers, the counter, the error flag and the stall OR.

## Test plan
- Reset, then issueValid=1, issueWa=8. Next cycle rsF=8, rsUsedF=1 → stallF=1 and pending[8]=1. Then wbValid=1, wbWa=8 → stallF=0 in that same cycle, and pending[8]=0 the next cycle.
- Issue to r5 is accepted. Next cycle issue to r5 again → stallF=1 (WAW) and outCnt stays 1. Then wbValid/wbWa=5 in the same cycle as the re-issue → accept, pending[5] stays 1, outCnt stays 1.
- MAX_OUT=4: issue to r1, r2, r3, r4 → outCnt=4. Issue to r6 → stallF=1. Same request with wbValid, wbWa=2 → accepted, outCnt=4, pending[2]=0, pending[6]=1.
- rsF=0, rsUsedF=1 and issueWa=0 with no pending state → stallF=0, pending unchanged, outCnt=0. wbValid with wbWa=0 → sbErr=1, outCnt=0.
- flush=1 together with issueValid=1, issueWa=9 while rsF=8 is pending → stallF=0, pending[9] stays 0. A writeback to r8 in the same cycle still clears r8.
- With outCnt=3, assert rst_n low asynchronously between clock edges → pending=0, outCnt=0 and sbErr=0 immediately.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions: register addressing and scoreboard sizing.
package reg_scoreboard_pkg;

  localparam int NREG_DEF = 32;     // architectural register count
  localparam int RA_W     = 5;      // register address width
  localparam int CNT_W    = 4;      // outstanding-write counter width (MAX_OUT <= 15)

  // Register address type, also used by the forwarding unit.
  typedef logic [RA_W-1:0] regAddr_t;

  localparam regAddr_t REG_ZERO = 5'd0;

  // r0 is hardwired to zero, so it never produces or consumes a hazard.
  function automatic logic isRealReg(regAddr_t a);
    return a != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_scoreboard_hazard_chk.sv
// Combinational hazard detection against the pending-write vector.
// A same-cycle legal writeback is bypassed so it releases its readers at once.
module sb_hazard_chk
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic [NREG-1:0] pending,
  input  regAddr_t        rsF,
  input  logic            rsUsedF,
  input  regAddr_t        rtF,
  input  logic            rtUsedF,
  input  logic            issueValid,
  input  regAddr_t        issueWa,
  input  logic            wbValid,
  input  regAddr_t        wbWa,
  output logic            rawA,
  output logic            rawB,
  output logic            waw,
  output logic            wbLegal
);

  logic [NREG-1:0] pendEff;

  // Per-register effective pending bit: masked by a writeback to that register.
  for (genvar r = 0; r < NREG; r++) begin : gPendEff
    if (r == 0) begin : gZero
      assign pendEff[r] = 1'b0;
    end else begin : gReal
      assign pendEff[r] = pending[r] & ~(wbValid & (wbWa == regAddr_t'(r)));
    end
  end

  // Hazard terms; r0 is excluded everywhere.
  always_comb begin
    rawA    = rsUsedF    & isRealReg(rsF)     & pendEff[rsF];
    rawB    = rtUsedF    & isRealReg(rtF)     & pendEff[rtF];
    waw     = issueValid & isRealReg(issueWa) & pendEff[issueWa];
    wbLegal = wbValid    & isRealReg(wbWa)    & pending[wbWa];
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Interlock scoreboard for long-latency writers (miss loads, mul/div).
// Tracks in-flight destinations and stalls Fetch on RAW/WAW or a full table.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  regAddr_t         rsF,
  input  regAddr_t         rtF,
  input  logic             rsUsedF,
  input  logic             rtUsedF,
  input  logic             issueValid,
  input  regAddr_t         issueWa,
  input  logic             flush,
  input  logic             wbValid,
  input  regAddr_t         wbWa,
  output logic             stallF,
  output logic [NREG-1:0]  pending,
  output logic [CNT_W-1:0] outCnt,
  output logic             sbErr
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic             rawA, rawB, waw, wbLegal;
  logic             full, accept;
  logic [NREG-1:0]  pendNext;
  logic [CNT_W-1:0] cntNext;

  sb_hazard_chk #(.NREG(NREG)) uHaz (
    .pending    (pending),
    .rsF        (rsF),
    .rsUsedF    (rsUsedF),
    .rtF        (rtF),
    .rtUsedF    (rtUsedF),
    .issueValid (issueValid),
    .issueWa    (issueWa),
    .wbValid    (wbValid),
    .wbWa       (wbWa),
    .rawA       (rawA),
    .rawB       (rawB),
    .waw        (waw),
    .wbLegal    (wbLegal)
  );

  // Stall and accept: flush kills the Fetch instruction, so it neither stalls nor issues.
  always_comb begin
    full   = (outCnt == CNT_MAX) & ~wbLegal;
    stallF = ~flush & (rawA | rawB | waw | (issueValid & full));
    accept = issueValid & isRealReg(issueWa) & ~stallF & ~flush;
  end

  // Next pending vector: clear on legal writeback, then set on accept so set wins.
  always_comb begin
    pendNext = pending;
    if (wbLegal) pendNext[wbWa]    = 1'b0;
    if (accept)  pendNext[issueWa] = 1'b1;
    pendNext[0] = 1'b0;
  end

  // Next count: an issue and a writeback in the same cycle cancel out.
  always_comb begin
    cntNext = outCnt;
    if (accept && !wbLegal)      cntNext = outCnt + CNT_W'(1);
    else if (!accept && wbLegal) cntNext = outCnt - CNT_W'(1);
  end

  // Tracking state; an illegal writeback leaves it untouched by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      outCnt  <= '0;
    end else begin
      pending <= pendNext;
      outCnt  <= cntNext;
    end
  end

  // Sticky error: writeback to r0 or to a register with no write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   sbErr <= 1'b0;
    else if (wbValid && !wbLegal) sbErr <= 1'b1;
  end

endmodule
